// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: PC, synchronous imem requests, and a prefetch FIFO with redirect flush.
// Optional macro FETCH_JMP_PREDECODE_EN folds JMP (opcode 8'h08) into the PC instead of delivering it.
module instr_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              squash_q, squash_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]       fifo_data_q [DEPTH];
  logic [31:0]       fifo_data_d [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_d [DEPTH];

  logic              resp_valid;
  logic              jmp_hit;
  logic              credit_ok;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    occupancy;

  always_comb begin
    resp_valid = inflight_q && !squash_q;
`ifdef FETCH_JMP_PREDECODE_EN
    jmp_hit    = resp_valid && (imem_rdata[31:24] == 8'h08);
`else
    jmp_hit    = 1'b0;
`endif
    // Registered count and inflight only: a same-cycle pop is not credited.
    occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    credit_ok  = occupancy < (CNT_W + 1)'(DEPTH);
    issue      = !rst && !redirect_valid && !jmp_hit && credit_ok;
    push       = resp_valid && !jmp_hit && !redirect_valid;
    instr_valid = !rst && (count_q != '0);
    pop        = instr_valid && instr_ready && !redirect_valid;

    imem_req   = issue;
    imem_addr  = rst ? '0 : pc_q;
    instr_data = instr_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    instr_pc   = instr_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? pc_q : inflight_pc_q;
    // A read issued alongside a redirect or jump would be stale; issue is blocked then, so this stays clear.
    squash_d      = issue && (redirect_valid || jmp_hit);
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_data_d   = fifo_data_q;
    fifo_pc_d     = fifo_pc_q;

    if (redirect_valid) begin
      pc_d     = redirect_addr;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (jmp_hit) begin
        pc_d = imem_rdata[16 +: ADDR_W];
      end else if (issue) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (push) begin
        fifo_data_d[wr_ptr_q] = imem_rdata;
        fifo_pc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      squash_q      <= 1'b0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      squash_q      <= squash_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_pc_q   <= fifo_pc_d;
  end

endmodule
